// File: rtl/bp_update_sched_if.sv
// ---------------------------------------------------------------------------
// bp_update_sched_if
// Bundle of every handshake and bus signal around the branch-predictor
// update scheduler.
//   ex_*        EX-stage conditional-branch outcome request (+ ex_ready)
//   id_*        ID-stage JAL outcome request (+ id_ready), flush kills it
//   upd_*       single update port into the BHT/BTB
//   init_*      predictor clear strobe / index used by the reset sweep
//   pred_enable fetch may consume predictions
//   stat_*      optional update statistics (0 when not built)
// Modports: slave = scheduler side, master = requester/predictor side.
// ---------------------------------------------------------------------------
interface bp_update_sched_if #(
    parameter int LOG_TABLE_NUM = 6
);
    logic                     ex_valid;
    logic [31:0]              ex_pc;
    logic [31:0]              ex_target;
    logic                     ex_taken;
    logic                     ex_ready;

    logic                     id_valid;
    logic [31:0]              id_pc;
    logic [31:0]              id_target;
    logic                     id_ready;
    logic                     flush;

    logic                     upd_valid;
    logic [31:0]              upd_pc_b;
    logic [31:0]              upd_pc_n;
    logic                     upd_taken;

    logic                     init_we;
    logic [LOG_TABLE_NUM-1:0] init_index;
    logic                     pred_enable;

    logic [31:0]              stat_upd_cnt;
    logic [31:0]              stat_taken_cnt;

    modport slave (
        input  ex_valid, ex_pc, ex_target, ex_taken,
        input  id_valid, id_pc, id_target, flush,
        output ex_ready, id_ready,
        output upd_valid, upd_pc_b, upd_pc_n, upd_taken,
        output init_we, init_index, pred_enable,
        output stat_upd_cnt, stat_taken_cnt
    );

    modport master (
        output ex_valid, ex_pc, ex_target, ex_taken,
        output id_valid, id_pc, id_target, flush,
        input  ex_ready, id_ready,
        input  upd_valid, upd_pc_b, upd_pc_n, upd_taken,
        input  init_we, init_index, pred_enable,
        input  stat_upd_cnt, stat_taken_cnt
    );
endinterface

// File: rtl/bp_update_sched.sv
// ---------------------------------------------------------------------------
// bp_update_sched
// Scheduler in front of the branch predictor's single update port. EX
// (conditional branches) and ID (JAL, always taken) outcomes are queued in
// arrival order in a small FIFO and one update per cycle is issued from the
// head. After reset a sweep drives the predictor clear port over every table
// index; predictions and request acceptance are held off until it finishes.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  bp_update_sched_if.slave (ex_*, id_*, flush, upd_*, init_*,
//        pred_enable, stat_*)
//
// Optional build macro: BP_STATS_EN -- adds 32-bit wrapping counters of
// issued updates and issued taken updates; otherwise stat_* are tied to 0.
// ---------------------------------------------------------------------------
module bp_update_sched #(
    parameter int QUEUE_DEPTH     = 4,
    parameter int LOG_QUEUE_DEPTH = 2,
    parameter int TABLE_NUM       = 64,
    parameter int LOG_TABLE_NUM   = 6
) (
    input  logic              clk,
    input  logic              rst,
    bp_update_sched_if.slave  bus
);

    localparam int                  CW       = LOG_QUEUE_DEPTH + 1;
    localparam int                  PW       = LOG_QUEUE_DEPTH;
    localparam int                  TW       = LOG_TABLE_NUM;
    localparam logic [CW-1:0]       DEPTH_C  = CW'(QUEUE_DEPTH);
    localparam logic [TW-1:0]       LAST_IDX = TW'(TABLE_NUM - 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } bp_entry_t;

    typedef enum logic {INIT, RUN} state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   sweep_cnt, sweep_nxt;

    bp_entry_t       mem [QUEUE_DEPTH];
    logic [PW-1:0]   head, tail, tail_id, rd_idx;
    logic [CW-1:0]   count, room_id;

    logic            run;
    logic            ex_rdy, id_rdy, ex_acc, id_acc, pop;
    bp_entry_t       ex_entry, id_entry, head_e;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep_cnt;
        if (state == INIT) begin
            if (sweep_cnt == LAST_IDX) begin
                state_nxt = RUN;
                sweep_nxt = '0;
            end else begin
                sweep_nxt = sweep_cnt + TW'(1);
            end
        end
    end

    // Gating with rst keeps the reset cycle itself quiet even when the state
    // register still says RUN: nothing is accepted or issued while rst is high.
    assign run = (state == RUN) && !rst;

    // ---------------- handshake ----------------
    // Readiness looks only at the pre-edge count; the same-cycle pop is not
    // credited so ready never depends on the issue path.
    assign ex_rdy  = run && (count < DEPTH_C);
    assign ex_acc  = bus.ex_valid && ex_rdy;
    assign room_id = count + CW'(ex_acc);
    assign id_rdy  = run && !bus.flush && (room_id < DEPTH_C);
    assign id_acc  = bus.id_valid && id_rdy;
    assign pop     = run && (count != '0);

    assign ex_entry = {bus.ex_pc, bus.ex_target, bus.ex_taken};
    assign id_entry = {bus.id_pc, bus.id_target, 1'b1};

    // EX is the older instruction, so it takes the first free slot.
    assign tail_id = tail + PW'(ex_acc);

    always_ff @(posedge clk) begin
        if (ex_acc) mem[tail]    <= ex_entry;
        if (id_acc) mem[tail_id] <= id_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PW'(ex_acc) + PW'(id_acc);
            if (pop) head <= head + PW'(1);
            count <= count + CW'(ex_acc) + CW'(id_acc) - CW'(pop);
        end
    end

    // When empty, the slot just behind head still holds the last issued entry
    // (the next write lands at head), so the outputs hold their last values.
    assign rd_idx = (count != '0) ? head : head - PW'(1);
    assign head_e = mem[rd_idx];

    // ---------------- outputs ----------------
    assign bus.ex_ready    = ex_rdy;
    assign bus.id_ready    = id_rdy;
    assign bus.upd_valid   = pop;
    assign bus.upd_pc_b    = head_e.pc;
    assign bus.upd_pc_n    = head_e.target;
    assign bus.upd_taken   = head_e.taken;
    assign bus.pred_enable = run;
    assign bus.init_we     = !run;
    assign bus.init_index  = (state == INIT && !rst) ? sweep_cnt : '0;

`ifdef BP_STATS_EN
    logic [31:0] upd_cnt_q, taken_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_cnt_q   <= '0;
            taken_cnt_q <= '0;
        end else begin
            if (pop)                upd_cnt_q   <= upd_cnt_q + 32'd1;
            if (pop && head_e.taken) taken_cnt_q <= taken_cnt_q + 32'd1;
        end
    end

    assign bus.stat_upd_cnt   = upd_cnt_q;
    assign bus.stat_taken_cnt = taken_cnt_q;
`else
    assign bus.stat_upd_cnt   = '0;
    assign bus.stat_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_bp_update_sched.sv
// ---------------------------------------------------------------------------
// tb_bp_update_sched
// Directed bench for bp_update_sched. Inputs change 1 time unit after the
// rising edge, outputs are looked at 1 unit later.
// ---------------------------------------------------------------------------
module tb_bp_update_sched;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bp_update_sched_if #(.LOG_TABLE_NUM(6)) bus ();

    bp_update_sched #(
        .QUEUE_DEPTH(4), .LOG_QUEUE_DEPTH(2), .TABLE_NUM(64), .LOG_TABLE_NUM(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus table for the mixed-traffic / wrap scenario. -1 = idle.
    // Request k: pc=0x1000+16k, target=0x2000+16k, ex taken=bit1 of k.
    int ex_req  [12] = '{0, 2, 4, 6, -1, 7, -1, 9, -1, -1, -1, -1};
    int id_req  [12] = '{1, 3, 5, 5, 5, 8, 8, -1, -1, -1, -1, -1};
    int exp_ir  [12] = '{1, 1, 0, 0, 1, 0, 1, 0, 1, 1, 1, 1};
    int exp_upd [12] = '{-1, 0, 1, 2, 3, 4, 6, 5, 7, 8, 9, -1};
    int exp_tk  [12] = '{0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ex_valid  = 1'b0;
        bus.ex_pc     = '0;
        bus.ex_target = '0;
        bus.ex_taken  = 1'b0;
        bus.id_valid  = 1'b0;
        bus.id_pc     = '0;
        bus.id_target = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        #1;
        checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("FAIL rst_upd_valid got %0b want 0", bus.upd_valid); end
        checks++; if (bus.ex_ready !== 1'b0) begin errors++; $display("FAIL rst_ex_ready got %0b want 0", bus.ex_ready); end
        checks++; if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL rst_id_ready got %0b want 0", bus.id_ready); end
        checks++; if (bus.pred_enable !== 1'b0) begin errors++; $display("FAIL rst_pred_enable got %0b want 0", bus.pred_enable); end
        checks++; if (bus.init_we !== 1'b1) begin errors++; $display("FAIL rst_init_we got %0b want 1", bus.init_we); end
        checks++; if (bus.init_index !== 6'd0) begin errors++; $display("FAIL rst_init_index got %0d want 0", bus.init_index); end
        checks++; if (bus.stat_upd_cnt !== 32'd0) begin errors++; $display("FAIL rst_stat_upd got %0d want 0", bus.stat_upd_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) begin
            checks++; if (bus.init_we !== 1'b1 || bus.init_index !== 6'(i)) begin
                errors++; $display("FAIL sweep_idx cyc %0d got we=%0b idx=%0d want we=1 idx=%0d", i, bus.init_we, bus.init_index, i); end
            checks++; if (bus.upd_valid !== 1'b0 || bus.pred_enable !== 1'b0 || bus.ex_ready !== 1'b0) begin
                errors++; $display("FAIL sweep_quiet cyc %0d got upd=%0b pe=%0b er=%0b want 0 0 0", i, bus.upd_valid, bus.pred_enable, bus.ex_ready); end
            tick();
            #1;
        end
        checks++; if (bus.pred_enable !== 1'b1) begin errors++; $display("FAIL run_pred_enable got %0b want 1", bus.pred_enable); end
        checks++; if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL run_ex_ready got %0b want 1", bus.ex_ready); end
        checks++; if (bus.init_we !== 1'b0 || bus.init_index !== 6'd0) begin
            errors++; $display("FAIL run_init got we=%0b idx=%0d want 0 0", bus.init_we, bus.init_index); end
        checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("FAIL run_upd_valid got %0b want 0", bus.upd_valid); end
        #8; // realign to posedge+1 (we are at posedge+2 here)
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_ex();
        bus.ex_valid = 1'b1; bus.ex_pc = 32'h100; bus.ex_target = 32'h140; bus.ex_taken = 1'b1;
        #1;
        checks++; if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL single_ex_ready got %0b want 1", bus.ex_ready); end
        checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("FAIL single_pre_upd got %0b want 0", bus.upd_valid); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.upd_valid !== 1'b1 || bus.upd_pc_b !== 32'h100 || bus.upd_pc_n !== 32'h140 || bus.upd_taken !== 1'b1) begin
            errors++; $display("FAIL single_upd got v=%0b b=%h n=%h t=%0b want 1 100 140 1", bus.upd_valid, bus.upd_pc_b, bus.upd_pc_n, bus.upd_taken); end
        tick();
        #1;
        checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle got %0b want 0", bus.upd_valid); end
        checks++; if (bus.upd_pc_b !== 32'h100 || bus.upd_pc_n !== 32'h140) begin
            errors++; $display("FAIL single_hold got b=%h n=%h want 100 140", bus.upd_pc_b, bus.upd_pc_n); end
        tick();
    endtask

    task automatic test_simultaneous();
        bus.ex_valid = 1'b1; bus.ex_pc = 32'h200; bus.ex_target = 32'h240; bus.ex_taken = 1'b0;
        bus.id_valid = 1'b1; bus.id_pc = 32'h300; bus.id_target = 32'h380;
        #1;
        checks++; if (bus.ex_ready !== 1'b1 || bus.id_ready !== 1'b1) begin
            errors++; $display("FAIL simul_ready got er=%0b ir=%0b want 1 1", bus.ex_ready, bus.id_ready); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.upd_valid !== 1'b1 || bus.upd_pc_b !== 32'h200 || bus.upd_pc_n !== 32'h240 || bus.upd_taken !== 1'b0) begin
            errors++; $display("FAIL simul_first got v=%0b b=%h n=%h t=%0b want 1 200 240 0", bus.upd_valid, bus.upd_pc_b, bus.upd_pc_n, bus.upd_taken); end
        tick();
        #1;
        checks++; if (bus.upd_valid !== 1'b1 || bus.upd_pc_b !== 32'h300 || bus.upd_pc_n !== 32'h380 || bus.upd_taken !== 1'b1) begin
            errors++; $display("FAIL simul_second got v=%0b b=%h n=%h t=%0b want 1 300 380 1", bus.upd_valid, bus.upd_pc_b, bus.upd_pc_n, bus.upd_taken); end
        tick();
        #1;
        checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("FAIL simul_drain got %0b want 0", bus.upd_valid); end
        tick();
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 12; c++) begin
            idle_inputs();
            if (ex_req[c] >= 0) begin
                bus.ex_valid  = 1'b1;
                bus.ex_pc     = 32'(32'h1000 + 16 * ex_req[c]);
                bus.ex_target = 32'(32'h2000 + 16 * ex_req[c]);
                bus.ex_taken  = ex_req[c][1];
            end
            if (id_req[c] >= 0) begin
                bus.id_valid  = 1'b1;
                bus.id_pc     = 32'(32'h1000 + 16 * id_req[c]);
                bus.id_target = 32'(32'h2000 + 16 * id_req[c]);
            end
            #1;
            checks++; if (bus.ex_ready !== 1'b1 || bus.id_ready !== 1'(exp_ir[c])) begin
                errors++; $display("FAIL bp_ready cyc %0d got er=%0b ir=%0b want 1 %0d", c, bus.ex_ready, bus.id_ready, exp_ir[c]); end
            checks++; if (bus.upd_valid !== (exp_upd[c] >= 0)) begin
                errors++; $display("FAIL bp_valid cyc %0d got %0b want %0b", c, bus.upd_valid, exp_upd[c] >= 0); end
            if (exp_upd[c] >= 0) begin
                checks++; if (bus.upd_pc_b !== 32'(32'h1000 + 16 * exp_upd[c]) || bus.upd_pc_n !== 32'(32'h2000 + 16 * exp_upd[c])
                              || bus.upd_taken !== 1'(exp_tk[c])) begin
                    errors++; $display("FAIL bp_entry cyc %0d got b=%h n=%h t=%0b want req %0d t=%0d", c, bus.upd_pc_b, bus.upd_pc_n, bus.upd_taken, exp_upd[c], exp_tk[c]); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        bus.ex_valid = 1'b1; bus.ex_pc = 32'h500; bus.ex_target = 32'h540; bus.ex_taken = 1'b1;
        bus.id_valid = 1'b1; bus.id_pc = 32'h600; bus.id_target = 32'h680; bus.flush = 1'b1;
        #1;
        checks++; if (bus.ex_ready !== 1'b1 || bus.id_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready got er=%0b ir=%0b want 1 0", bus.ex_ready, bus.id_ready); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.upd_valid !== 1'b1 || bus.upd_pc_b !== 32'h500) begin
            errors++; $display("FAIL flush_ex_issued got v=%0b b=%h want 1 500", bus.upd_valid, bus.upd_pc_b); end
        tick();
        #1;
        checks++; if (bus.upd_valid !== 1'b0) begin
            errors++; $display("FAIL flush_id_dropped got v=%0b b=%h want 0", bus.upd_valid, bus.upd_pc_b); end
        tick();
`ifdef BP_STATS_EN
        checks++; if (bus.stat_upd_cnt !== 32'd14 || bus.stat_taken_cnt !== 32'd10) begin
            errors++; $display("FAIL stats_count got upd=%0d tk=%0d want 14 10", bus.stat_upd_cnt, bus.stat_taken_cnt); end
`else
        checks++; if (bus.stat_upd_cnt !== 32'd0 || bus.stat_taken_cnt !== 32'd0) begin
            errors++; $display("FAIL stats_tied got upd=%0d tk=%0d want 0 0", bus.stat_upd_cnt, bus.stat_taken_cnt); end
`endif
    endtask

    task automatic test_reset_mid_run();
        bus.ex_valid = 1'b1; bus.ex_pc = 32'h700; bus.ex_target = 32'h740; bus.ex_taken = 1'b0;
        bus.id_valid = 1'b1; bus.id_pc = 32'h710; bus.id_target = 32'h750;
        tick();
        bus.ex_pc = 32'h720; bus.ex_target = 32'h760;
        bus.id_pc = 32'h730; bus.id_target = 32'h770;
        #1;
        checks++; if (bus.upd_valid !== 1'b1 || bus.upd_pc_b !== 32'h700) begin
            errors++; $display("FAIL mid_pre_issue got v=%0b b=%h want 1 700", bus.upd_valid, bus.upd_pc_b); end
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        checks++; if (bus.upd_valid !== 1'b0 || bus.ex_ready !== 1'b0 || bus.id_ready !== 1'b0) begin
            errors++; $display("FAIL mid_rst_quiet got v=%0b er=%0b ir=%0b want 0 0 0", bus.upd_valid, bus.ex_ready, bus.id_ready); end
        checks++; if (bus.init_we !== 1'b1 || bus.init_index !== 6'd0 || bus.pred_enable !== 1'b0) begin
            errors++; $display("FAIL mid_rst_init got we=%0b idx=%0d pe=%0b want 1 0 0", bus.init_we, bus.init_index, bus.pred_enable); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.stat_upd_cnt !== 32'd0 || bus.stat_taken_cnt !== 32'd0) begin
            errors++; $display("FAIL mid_stats_clr got upd=%0d tk=%0d want 0 0", bus.stat_upd_cnt, bus.stat_taken_cnt); end
        for (int i = 0; i < 64; i++) begin
            checks++; if (bus.init_index !== 6'(i) || bus.upd_valid !== 1'b0) begin
                errors++; $display("FAIL mid_sweep cyc %0d got idx=%0d v=%0b want idx=%0d v=0", i, bus.init_index, bus.upd_valid, i); end
            tick();
            #1;
        end
        checks++; if (bus.pred_enable !== 1'b1 || bus.upd_valid !== 1'b0) begin
            errors++; $display("FAIL mid_run_empty got pe=%0b v=%0b want 1 0", bus.pred_enable, bus.upd_valid); end
        tick();
        #1;
        checks++; if (bus.upd_valid !== 1'b0 || bus.stat_upd_cnt !== 32'd0) begin
            errors++; $display("FAIL mid_no_stale got v=%0b upd_cnt=%0d want 0 0", bus.upd_valid, bus.stat_upd_cnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_ex();
        test_simultaneous();
        test_backpressure();
        test_flush();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
